// File: rtl/sel3_ctl_pkg.sv
// Shared types and constants for the sel3 grant controller: FSM states,
// one-hot selector codes (source 0 drives A, the MSB) and source indices.
package sel3_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    XFER = 1'b1
  } state_e;

  localparam logic [2:0] SEL_I0   = 3'b100;
  localparam logic [2:0] SEL_I1   = 3'b010;
  localparam logic [2:0] SEL_I2   = 3'b001;
  localparam logic [2:0] SEL_NONE = 3'b000;

  localparam logic [1:0] SRC0 = 2'd0;
  localparam logic [1:0] SRC1 = 2'd1;
  localparam logic [1:0] SRC2 = 2'd2;

  function automatic logic [2:0] src_sel(input logic [1:0] idx);
    case (idx)
      SRC0:    return SEL_I0;
      SRC1:    return SEL_I1;
      default: return SEL_I2;
    endcase
  endfunction

  function automatic logic [1:0] sel_idx(input logic [2:0] sel);
    case (sel)
      SEL_I0:  return SRC0;
      SEL_I1:  return SRC1;
      default: return SRC2;
    endcase
  endfunction

endpackage

// File: rtl/sel3_ctl_if.sv
// Request/grant bundle between three sources, the selector and its consumer.
// master = grant controller, slave = the environment that requests and accepts beats.
interface sel3_ctl_if #(
  parameter int LEN_W = 4
);
  logic             REQ0;
  logic             REQ1;
  logic             REQ2;
  logic [LEN_W-1:0] LEN;
  logic             RDY;
  logic             A;
  logic             B;
  logic             C;
  logic             E;
  logic             LAST;
  logic             ABORT;

  modport master (
    input  REQ0, REQ1, REQ2, LEN, RDY,
    output A, B, C, E, LAST, ABORT
  );

  modport slave (
    output REQ0, REQ1, REQ2, LEN, RDY,
    input  A, B, C, E, LAST, ABORT
  );
endinterface

// File: rtl/sel3_ctl_rr_pick3.sv
// Combinational three-way rotating-priority picker; zero latency, no backpressure.
// Search order starts just after the previous winner: last+1, last+2, last (mod 3).
module rr_pick3
  import sel3_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] last_i,
  output logic [2:0] gnt_o,
  output logic       vld_o
);

  logic [1:0] p0, p1, p2;

  always_comb begin
    p0 = SRC0;
    p1 = SRC1;
    p2 = SRC2;
    case (last_i)
      SRC0: begin
        p0 = SRC1;
        p1 = SRC2;
        p2 = SRC0;
      end
      SRC1: begin
        p0 = SRC2;
        p1 = SRC0;
        p2 = SRC1;
      end
      default: ;
    endcase

    gnt_o = SEL_NONE;
    if (req_i[p0])      gnt_o = src_sel(p0);
    else if (req_i[p1]) gnt_o = src_sel(p1);
    else if (req_i[p2]) gnt_o = src_sel(p2);
  end

  assign vld_o = |req_i;

endmodule

// File: rtl/sel3_ctl.sv
// Round-robin burst grant controller driving selector A/B/C/E; 1-cycle grant latency, no bubble
// between bursts, RDY=0 freezes the burst. Macro SEL3_CTL_TIMEOUT_EN adds a stall-abort path.
module sel3_ctl
  import sel3_pkg::*;
#(
  parameter int LEN_W   = 4
`ifdef SEL3_CTL_TIMEOUT_EN
  ,
  parameter int TIMEOUT = 15
`endif
) (
  input  logic       CLK,
  input  logic       RST_N,
  sel3_ctl_if.master bus
);

  state_e           state_q;
  logic [2:0]       gnt_q;
  logic [1:0]       last_gnt_q;
  logic [LEN_W-1:0] cnt_q;
  logic [LEN_W-1:0] len_q;

  logic [2:0] pick_gnt;
  logic       pick_vld;
  logic       e_w;
  logic       last_w;
  logic       abort_now;
  logic       arb_pt;

  rr_pick3 u_pick (
    .req_i  ({bus.REQ2, bus.REQ1, bus.REQ0}),
    .last_i (last_gnt_q),
    .gnt_o  (pick_gnt),
    .vld_o  (pick_vld)
  );

  assign e_w    = |gnt_q;
  assign last_w = e_w && (cnt_q == len_q);

  // A timeout abort re-arbitrates on the same edge, exactly like a final beat.
  assign arb_pt = (state_q == IDLE)
               || ((state_q == XFER) && bus.RDY && last_w)
               || abort_now;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q    <= IDLE;
      gnt_q      <= SEL_NONE;
      last_gnt_q <= SRC2;
      cnt_q      <= '0;
      len_q      <= '0;
    end else if (arb_pt) begin
      if (pick_vld) begin
        state_q    <= XFER;
        gnt_q      <= pick_gnt;
        last_gnt_q <= sel_idx(pick_gnt);
        len_q      <= bus.LEN;
        cnt_q      <= '0;
      end else begin
        state_q <= IDLE;
        gnt_q   <= SEL_NONE;
      end
    end else if ((state_q == XFER) && bus.RDY) begin
      cnt_q <= cnt_q + LEN_W'(1);
    end
  end

`ifdef SEL3_CTL_TIMEOUT_EN
  localparam int STALL_W = $clog2(TIMEOUT + 1);

  logic [STALL_W-1:0] stall_q;
  logic               abort_q;

  // stall_q holds the stalls already seen, so the current cycle is stall number stall_q+1.
  assign abort_now = (state_q == XFER) && !bus.RDY
                  && (stall_q == STALL_W'(TIMEOUT - 1));

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      stall_q <= '0;
      abort_q <= 1'b0;
    end else begin
      abort_q <= abort_now;
      if (arb_pt || bus.RDY)     stall_q <= '0;
      else if (state_q == XFER)  stall_q <= stall_q + STALL_W'(1);
    end
  end

  assign bus.ABORT = abort_q;
`else
  assign abort_now = 1'b0;
  assign bus.ABORT = 1'b0;
`endif

  assign bus.A    = gnt_q[2];
  assign bus.B    = gnt_q[1];
  assign bus.C    = gnt_q[0];
  assign bus.E    = e_w;
  assign bus.LAST = last_w;

endmodule

// File: tb/tb_sel3_ctl.sv
// Bench for sel3_ctl: directed scenarios plus random traffic against a burst-level reference model.
module tb_sel3_ctl;

  localparam int LW  = 4;
  localparam int TMO = 15;
`ifdef SEL3_CTL_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  sel3_ctl_if #(.LEN_W(LW)) bus ();

  sel3_ctl #(.LEN_W(LW)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Reference model: who owns the selector and how many beats are still owed.
  bit m_busy;
  int m_owner;
  int m_left;
  int m_last;
  int m_stall;
  bit m_abort;

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) n_pass = n_pass + 1;
    else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
  endtask

  task automatic model_step();
    bit         decide;
    int         s;
    logic [2:0] r;
    if (!rst_n) begin
      m_busy  = 1'b0;
      m_owner = 0;
      m_left  = 0;
      m_last  = 2;
      m_stall = 0;
      m_abort = 1'b0;
    end else begin
      m_abort = 1'b0;
      decide  = !m_busy;
      if (m_busy) begin
        if (bus.RDY) begin
          m_left  = m_left - 1;
          m_stall = 0;
          if (m_left == 0) decide = 1'b1;
        end else begin
          m_stall = m_stall + 1;
          if (TMO_EN && m_stall == TMO) begin
            m_abort = 1'b1;
            decide  = 1'b1;
          end
        end
      end
      if (decide) begin
        r       = {bus.REQ2, bus.REQ1, bus.REQ0};
        m_busy  = 1'b0;
        m_stall = 0;
        for (int k = 1; k <= 3; k++) begin
          s = (m_last + k) % 3;
          if (!m_busy && r[s]) begin
            m_busy  = 1'b1;
            m_owner = s;
            m_left  = int'(bus.LEN) + 1;
            m_last  = s;
          end
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    logic [2:0] eg;
    eg = m_busy ? (3'b100 >> m_owner) : 3'b000;
    chk({tag, ".abc"},   {1'b0, bus.A, bus.B, bus.C}, {1'b0, eg});
    chk({tag, ".e"},     {3'b0, bus.E},     {3'b0, m_busy});
    chk({tag, ".last"},  {3'b0, bus.LAST},  {3'b0, (m_busy && m_left == 1)});
    chk({tag, ".abort"}, {3'b0, bus.ABORT}, {3'b0, m_abort});
  endtask

  task automatic tick(input string tag);
    check_outs(tag);
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic set_in(input logic [2:0] req, input int len, input logic rdy);
    bus.REQ0 = req[0];
    bus.REQ1 = req[1];
    bus.REQ2 = req[2];
    bus.LEN  = LW'(len);
    bus.RDY  = rdy;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    model_step();
    #1;
    check_outs("rst");
    chk("rst.abcel", {bus.A, bus.B, bus.C, bus.E}, 4'b0000);
    rst_n = 1'b1;
  endtask

  logic [3:0] rr_exp [7] = '{4'b0100, 4'b0100, 4'b0010, 4'b0010, 4'b0001, 4'b0001, 4'b0100};
  int   beats;
  int   last_at;
  logic rdy_t;
  int   aborts;

  initial begin
    set_in(3'b000, 0, 1'b0);
    rst_n = 1'b0;
    do_reset();

    // Single-beat burst to source 0, then idle once the request drops.
    set_in(3'b001, 0, 1'b1);
    tick("t1a");
    chk("t1.grant", {bus.A, bus.B, bus.C, bus.LAST}, 4'b1001);
    bus.REQ0 = 1'b0;
    tick("t1b");
    chk("t1.idle", {3'b0, bus.E}, 4'b0000);

    // All three requesting, two-beat bursts, strict rotation with no bubble.
    do_reset();
    set_in(3'b111, 1, 1'b1);
    for (int i = 0; i < 7; i++) begin
      tick("t2");
      chk("t2.rr", {1'b0, bus.A, bus.B, bus.C}, rr_exp[i]);
    end

    // Source 1 alone, four beats with RDY alternating.
    do_reset();
    set_in(3'b010, 3, 1'b1);
    tick("t3g");
    bus.REQ1 = 1'b0;
    beats   = 0;
    last_at = 0;
    rdy_t   = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (!bus.E) break;
      bus.RDY = rdy_t;
      if (bus.RDY) begin
        beats = beats + 1;
        if (bus.LAST) last_at = beats;
      end
      tick("t3");
      rdy_t = ~rdy_t;
    end
    chk("t3.beats", 4'(beats), 4'd4);
    chk("t3.last_at", 4'(last_at), 4'd4);

    // Maximum length burst: 16 beats without counter wrap.
    do_reset();
    set_in(3'b001, 15, 1'b1);
    tick("t5g");
    bus.REQ0 = 1'b0;
    beats = 0;
    for (int i = 0; i < 20; i++) begin
      if (!bus.E) break;
      beats = beats + 1;
      tick("t5");
    end
    chk("t5.beats", 4'(beats - 1), 4'd15);

    // Reset in the middle of a source 2 burst.
    do_reset();
    set_in(3'b100, 7, 1'b1);
    tick("t4g");
    tick("t4b");
    tick("t4c");
    set_in(3'b111, 7, 1'b1);
    rst_n = 1'b0;
    tick("t4r");
    chk("t4.rst", {bus.A, bus.B, bus.C, bus.E}, 4'b0000);
    chk("t4.rstl", {2'b0, bus.LAST, bus.ABORT}, 4'b0000);
    rst_n = 1'b1;
    tick("t4n");
    chk("t4.first", {1'b0, bus.A, bus.B, bus.C}, 4'b0100);

`ifdef SEL3_CTL_TIMEOUT_EN
    // Stall source 1 until it times out; pending source 2 takes over on the abort edge.
    do_reset();
    set_in(3'b010, 3, 1'b0);
    tick("t6g");
    set_in(3'b100, 3, 1'b0);
    aborts = 0;
    for (int i = 0; i < 20; i++) begin
      tick("t6");
      if (bus.ABORT) begin
        aborts = aborts + 1;
        chk("t6.when", 4'(i + 1), 4'(TMO));
        chk("t6.next", {bus.E, bus.A, bus.B, bus.C}, 4'b1001);
      end
    end
    chk("t6.aborts", 4'(aborts), 4'd1);
`endif

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      set_in(3'($urandom_range(0, 7)),
             ($urandom_range(0, 7) == 0) ? 15 : int'($urandom_range(0, 3)),
             ($urandom_range(0, 3) != 0));
      rst_n = ($urandom_range(0, 79) != 0);
      tick("rnd");
    end
    rst_n = 1'b1;
    set_in(3'b000, 0, 1'b1);
    tick("end");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/sel3_ctl.md
# sel3_ctl

Round-robin grant controller that sits directly upstream of the 3-to-6-bit selector and drives its one-hot select lines (A, B, C) and enable (E). It arbitrates among three requesting 6-bit sources. It holds the winning grant for a per-grant burst of beats, with a beat accepted when the downstream consumer signals ready. It then rotates priority so that no source starves.

## Interface
- `LEN_W`, default 4: width of burst-length input; bursts are 1..2^LEN_W beats.
- `TIMEOUT`, default 15: stall cycles before abort; used only with the timeout feature.
- `CLK`  in  1  clock; all state changes on rising edge.
- `RST_N`  in  1  reset; synchronous and active-low.
- `REQ0`/`REQ1`/`REQ2`  in  1 each  request from source 0/1/2; sampled only at arbitration points.
- `LEN`  in  LEN_W  burst length minus one; latched at grant.
- `RDY`  in  1  downstream ready; a beat transfers on a cycle with E && RDY.
- `A`/`B`/`C`  out  1 each  one-hot grant for source 0/1/2, so {A,B,C} = 3'b100/010/001; all zero when idle.
- `E`  out  1  selector enable; high exactly while a grant is active.
- `LAST`  out  1  high when the current beat, if accepted, is the final beat of the burst.
- `ABORT`  out  1  one-cycle pulse when a burst is killed by timeout.

## Operation
- State machine states: IDLE and XFER.
- Registers:
  - grant {A,B,C}
  - pointer `LAST_GNT` (2 bits, index of the most recent winner)
  - beat counter `CNT` (LEN_W bits)
  - latched length `LEN_Q`
- Arbitration order starts after the previous winner: (LAST_GNT+1, LAST_GNT+2, LAST_GNT) mod 3.
- Arbitration points are (a) every cycle in IDLE and (b) the cycle of the last beat in XFER (E && RDY && LAST).
- At an arbitration point with any request pending:
  - the winner's one-hot code is registered to {A,B,C} and E=1;
  - LEN_Q <= LEN, CNT <= 0, LAST_GNT <= winner;
  - state becomes XFER.
- At an arbitration point with no request pending: {A,B,C}=0, E=0, state becomes IDLE, and LAST_GNT is unchanged.
- In XFER:
  - each accepted beat (RDY=1) that is not the last beat increments CNT;
  - with RDY=0, all registers hold.
- LAST = E && (CNT == LEN_Q). This is combinational from registers.
- A request dropped mid-burst does not shorten the burst. A request is never re-granted mid-burst.
- The outputs never hold more than one of A, B, C high. E == (A|B|C) at all times.
- When RST_N=0 at a rising edge, all of the following take effect on that edge regardless of any in-flight burst:
  - state IDLE;
  - A=B=C=E=0, LAST=0, ABORT=0;
  - CNT=0, LEN_Q=0;
  - LAST_GNT=2, so source 0 has top priority first.

## Timing
- Grant latency is 1 cycle: a request sampled at edge n in IDLE gives E=1 after edge n.
- Back-to-back bursts have no bubble: the edge that accepts the last beat loads the next grant.
- A burst occupies exactly LEN_Q+1 accepted beats. Stall cycles extend it.
- LEN = 0 gives a 1-beat burst with LAST high on the first grant cycle.
- LEN = 2^LEN_W−1 gives 2^LEN_W beats, and CNT does not wrap before LAST.
- Simultaneous requests resolve strictly by rotating priority. When the same source wins again, it is because it is the only requester.

## Configuration
- `SEL3_CTL_TIMEOUT_EN` defined:
  - a stall counter counts consecutive XFER cycles with RDY=0 and clears on any RDY=1 cycle;
  - when it reaches TIMEOUT, ABORT pulses for one cycle and the grant drops on that edge;
  - arbitration then runs as at a normal arbitration point, with LAST_GNT already set to the aborted source.
- `SEL3_CTL_TIMEOUT_EN` not defined: no stall counter, ABORT is tied to 0, and XFER waits indefinitely.

## Structure
- Package `sel3_pkg` holds:
  - the state enum (IDLE, XFER);
  - one-hot grant constants SEL_I0=3'b100, SEL_I1=3'b010, SEL_I2=3'b001, SEL_NONE=3'b000;
  - source index constants.
- Sub-module `rr_pick3` is a combinational rotating-priority picker: req[2:0] and last[1:0] in, one-hot grant and valid out. It is reused wherever three-way round-robin is needed.

## Test plan
- Reset, then REQ0=1 with LEN=0 and RDY=1 held: {A,B,C}=100 and E=1 one cycle after the request, LAST=1, then E=0 in the next cycle if REQ0 has dropped.
- REQ0, REQ1 and REQ2 all held, with LEN=1 and RDY=1: grants run 100,100,010,010,001,001,100,… with no idle cycle between bursts.
- REQ1 only with LEN=3, and RDY toggling 1,0,1,0,…: exactly 4 accepted beats, LAST on the 4th, and all registers frozen on RDY=0 cycles.
- RST_N=0 asserted mid-burst on source 2: after that edge all outputs are 0. With all requests then held, the first grant goes to source 0.
- With `SEL3_CTL_TIMEOUT_EN` and TIMEOUT=15, grant source 1 and hold RDY=0: ABORT pulses once after 15 stall cycles, E drops on that edge, and a pending REQ2 is granted on that same edge.
